opcode_assembler: RTL and testbench
===================================

# opcode_assembler

Reassembles a 32-bit `dword_t` address from a stream of 16-bit `word_t` halves: instruction (high) half first, absolute (low) half second. It is the inverse of the opcode split path: upstream serial sources deliver `{instruction, absolute}` pairs, and this block rebuilds `{instruction, absolute}` into a full address. Assembled addresses are buffered in a small FIFO with valid/ready handshakes on both sides. Uses the `definitions` package types.

## Interface

Parameters:
- `DEPTH`, default 2: output FIFO depth in `dword_t` entries. Legal values are 2, 4 and 8.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — input word present.
- `in_ready`  out  1  — block accepts the input word this cycle.
- `in_word`  in  16 (`word_t`)  — input half-word.
- `in_first`  in  1  — 1 = `in_word` is the instruction (high) half; 0 = absolute (low) half.
- `out_valid`  out  1  — FIFO head holds an assembled address.
- `out_ready`  in  1  — consumer takes the head this cycle.
- `address`  out  32 (`dword_t`)  — FIFO head; `32'h0` when `out_valid` = 0.
- `count`  out  `$clog2(DEPTH+1)`  — current FIFO occupancy.
- `sync_err`  out  1  — one-cycle pulse on a half-ordering violation.

## Operation

- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- FSM states:
  - WAIT_HI is the reset state.
  - WAIT_LO means the high half is latched in `hi_q`.
- In WAIT_HI, on an input transfer:
  - `in_first` = 1: `hi_q <= in_word`, go to WAIT_LO.
  - `in_first` = 0: discard the word, pulse `sync_err`, stay in WAIT_HI.
- In WAIT_LO, on an input transfer:
  - `in_first` = 0: push `{hi_q, in_word}` into the FIFO, go to WAIT_HI.
  - `in_first` = 1: overwrite `hi_q` with `in_word`, pulse `sync_err`, stay in WAIT_LO. No push.
- `in_ready` = (state == WAIT_HI) || (`count` < DEPTH).
  - No combinational path from `out_ready` to `in_ready`.
  - A full FIFO with a pop in the same cycle does not admit a low half that cycle.
- FIFO ordering and counting:
  - Order is strict FIFO.
  - Read and write pointers wrap modulo DEPTH.
  - `count` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Push is never attempted when full (guaranteed by `in_ready`). Pop is never attempted when empty (guaranteed by `out_valid` = `count` != 0).
- `address` is stable while `out_valid && !out_ready`.
- Bit mapping: `address[31:16]` = instruction half, `address[15:0]` = absolute half.

## Timing

- Reset values:
  - State WAIT_HI.
  - `count` = 0, `out_valid` = 0, `address` = 0, `sync_err` = 0.
  - `in_ready` = 1.
  - Pointers = 0; `hi_q` = 0.
- Reset asserted mid-pair discards `hi_q` and all FIFO contents. A low half arriving after reset produces a `sync_err` pulse.
- Latency: a low half accepted at edge N with the FIFO empty gives `out_valid` = 1 and a valid `address` in the cycle following edge N, i.e. one cycle.
- Throughput: one address per two input cycles sustained, with `out_ready` held at 1.
- `sync_err` is registered. It is high for exactly the cycle after the offending transfer edge.
- All outputs are registered state or decoded from registered state. None depends combinationally on `in_valid`, `in_word` or `out_ready`.

## Test plan

1. **Basic pair.** With `out_ready` = 1, send `DEAD` (first = 1) then `BEEF` (first = 0) on consecutive cycles.
   - `address` = `DEADBEEF` with `out_valid` = 1 for one cycle, starting 1 cycle after the `BEEF` transfer. `count` goes 0→1→0.
2. **Backpressure and full.** With DEPTH = 2 and `out_ready` = 0, send pairs `1234/5678` and `9ABC/DEF0`, then `1111` (first = 1).
   - `1111` is accepted, `in_ready` = 0 in WAIT_LO, `count` = 2.
   - Offer `2222` (first = 0) while stalled: it is held.
   - Raise `out_ready`: outputs are `12345678`, `9ABCDEF0`, `11112222` in order.
3. **Ordering errors.**
   - In WAIT_HI, send `5555` (first = 0): `sync_err` pulses, no output.
   - Send `AAAA` (first = 1) then `BBBB` (first = 1): `sync_err` pulses again.
   - Send `CCCC` (first = 0): output `BBBBCCCC`.
4. **Reset mid-operation.** With the FIFO holding one entry, accept `AAAA` (first = 1), then assert `reset` for 1 cycle.
   - `out_valid` = 0, `count` = 0, `address` = 0.
   - A following `BBBB` (first = 0) gives a `sync_err` pulse and no output.
5. **Simultaneous push/pop.** With `count` = 1 and `out_ready` = 1, complete a pair in the same cycle the head pops.
   - `count` stays 1, and the new address appears as head the next cycle.
6. **Wrap-around.** With DEPTH = 4, stream 10 pairs `0000000n` under random `out_ready`.
   - All 10 addresses are received in order; there is no loss or duplication across pointer wrap.

Source files
------------

// File: rtl/opcode_assembler.sv
// Rebuilds 32-bit addresses from instruction/absolute 16-bit halves and
// queues them in a small output FIFO with valid/ready on both sides.
package definitions;
    typedef logic [15:0] word_t;
    typedef logic [31:0] dword_t;
endpackage

// Handshake rule on both ports: a transfer happens on a rising edge where
// valid && ready are both high; valid never waits on ready.
module opcode_assembler
    import definitions::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  word_t                      in_word,
    input  logic                       in_first,
    output logic                       out_valid,
    input  logic                       out_ready,
    output dword_t                     address,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       sync_err,
    output logic                       dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    word_t           r_hi;
    dword_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_sync_err;

    logic            w_in_fire;
    logic            w_load_hi;
    logic            w_push;
    logic            w_pop;
    logic            w_err;

    // in_ready looks only at registered state, so a pop never frees a slot
    // for a low half in the same cycle.
    assign in_ready  = (r_state == WAIT_HI) || (r_count < CW'(DEPTH));
    assign w_in_fire = in_valid && in_ready;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;
    assign address   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;
    assign sync_err  = r_sync_err;
    assign dbg_state = r_state;

    always_comb begin
        w_next_state = r_state;
        w_load_hi    = 1'b0;
        w_push       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            WAIT_HI: begin
                if (w_in_fire) begin
                    if (in_first) begin
                        w_load_hi    = 1'b1;
                        w_next_state = WAIT_LO;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            WAIT_LO: begin
                if (w_in_fire) begin
                    if (in_first) begin
                        // A fresh high half replaces the stale one.
                        w_load_hi = 1'b1;
                        w_err     = 1'b1;
                    end else begin
                        w_push       = 1'b1;
                        w_next_state = WAIT_HI;
                    end
                end
            end
            default: w_next_state = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= WAIT_HI;
            r_hi       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_sync_err <= w_err;
            if (w_load_hi) begin
                r_hi <= in_word;
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: address is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_hi, in_word};
        end
    end

endmodule

// File: tb/tb_opcode_assembler.sv
// Drives two assemblers (DEPTH 2 and 4) with shared inputs and compares every
// output each cycle against a queue-based model of the pairing rules.
module tb_opcode_assembler;
    import definitions::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    word_t       in_word;
    logic        in_first;
    logic        out_ready;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  sync_err;
    logic [1:0]  dbg_state;
    dword_t      address [2];
    logic [1:0]  count0;
    logic [2:0]  count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    opcode_assembler #(.DEPTH(2)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_word(in_word), .in_first(in_first), .out_valid(out_valid[0]),
        .out_ready(out_ready), .address(address[0]), .count(count0),
        .sync_err(sync_err[0]), .dbg_state(dbg_state[0])
    );

    opcode_assembler #(.DEPTH(4)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_word(in_word), .in_first(in_first), .out_valid(out_valid[1]),
        .out_ready(out_ready), .address(address[1]), .count(count1),
        .sync_err(sync_err[1]), .dbg_state(dbg_state[1])
    );

    // Reference model: "holding a high half" flag, the held half, and a queue
    // of assembled addresses waiting to be consumed.
    int          depth_of [2] = '{2, 4};
    bit          have_hi  [2];
    logic [15:0] hi_m     [2];
    logic [31:0] exp_q    [2][$];
    bit          err_m    [2];
    bit          fired    [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready(input int d);
        return !have_hi[d] || (exp_q[d].size() < depth_of[d]);
    endfunction

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] cnt;
            logic [31:0] head;
            cnt  = (d == 0) ? 32'(count0) : 32'(count1);
            head = (exp_q[d].size() != 0) ? exp_q[d][0] : 32'h0;
            check_eq($sformatf("d%0d_in_ready", d), 32'(in_ready[d]), 32'(model_ready(d)));
            check_eq($sformatf("d%0d_out_valid", d), 32'(out_valid[d]), 32'(exp_q[d].size() != 0));
            check_eq($sformatf("d%0d_address", d), address[d], head);
            check_eq($sformatf("d%0d_count", d), cnt, 32'(exp_q[d].size()));
            check_eq($sformatf("d%0d_sync_err", d), 32'(sync_err[d]), 32'(err_m[d]));
            check_eq($sformatf("d%0d_state", d), 32'(dbg_state[d]), 32'(have_hi[d]));
        end
    endtask

    task automatic model_step(input logic v, input logic [15:0] w, input logic f,
                              input logic ordy, input logic rst);
        for (int d = 0; d < 2; d++) begin
            bit pop;
            bit push;
            logic [31:0] pushed;
            fired[d] = !rst && v && model_ready(d);
            if (rst) begin
                have_hi[d] = 0;
                hi_m[d]    = '0;
                exp_q[d].delete();
                err_m[d]   = 0;
            end else begin
                pop      = (exp_q[d].size() != 0) && ordy;
                push     = 0;
                pushed   = '0;
                err_m[d] = 0;
                if (fired[d]) begin
                    if (f) begin
                        err_m[d]   = have_hi[d];
                        hi_m[d]    = w;
                        have_hi[d] = 1;
                    end else if (have_hi[d]) begin
                        push       = 1;
                        pushed     = {hi_m[d], w};
                        have_hi[d] = 0;
                    end else begin
                        err_m[d] = 1;
                    end
                end
                if (pop) void'(exp_q[d].pop_front());
                if (push) exp_q[d].push_back(pushed);
            end
        end
    endtask

    // One clock: check outputs mid-cycle, apply new inputs, advance the model.
    task automatic cyc(input logic v, input logic [15:0] w, input logic f,
                       input logic ordy, input logic rst);
        @(negedge clk);
        check_all();
        in_valid  = v;
        in_word   = w;
        in_first  = f;
        out_ready = ordy;
        reset     = rst;
        model_step(v, w, f, ordy, rst);
    endtask

    // Offer a word until instance d accepts it, bounded.
    task automatic send(input int d, input logic [15:0] w, input logic f, input logic ordy_rand);
        int n;
        n = 0;
        do begin
            cyc(1'b1, w, f, ordy_rand ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
            n++;
        end while (!fired[d] && n < 100);
        check_eq("send_accept", 32'(fired[d]), 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_word = '0; in_first = 1'b0; out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            have_hi[d] = 0; hi_m[d] = '0; err_m[d] = 0; fired[d] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Basic pair.
        cyc(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Backpressure until full, low half held, then drain.
        cyc(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h5678, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h9ABC, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'hDEF0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h1111, 1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Ordering errors.
        cyc(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 16'hAAAA, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 16'hBBBB, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Reset mid-pair with one FIFO entry held.
        cyc(1'b1, 16'h4321, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h8765, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Simultaneous push and pop at count 1.
        cyc(1'b1, 16'h0101, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0303, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0404, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Wrap-around on the deeper instance under random out_ready.
        for (int n = 1; n <= 10; n++) begin
            send(1, 16'h0000, 1'b1, 1'b1);
            send(1, 16'(n), 1'b0, 1'b1);
        end
        repeat (12) cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) == 0));
        end
        repeat (10) cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
